// File: rtl/instr_loader.sv
// instr_loader: boot-time program loader for the single-cycle MIPS core.
// Receives a byte stream (2-byte word count N, N big-endian 32-bit words,
// 1 XOR checksum byte), writes each word into instruction memory, and holds
// the core until the image is written and the checksum verified.
//
// Ports:
//   clock, reset      system clock; synchronous active-high reset
//   in_data/in_valid  incoming stream byte and its qualifier
//   in_ready          loader accepts a byte this cycle (registered state only)
//   write_address     instruction memory word index (zero-extended)
//   write_data        assembled instruction word
//   sig_instr_write   one-cycle write strobe
//   sig_cpu_hold      high keeps the core's pc from advancing
//   word_count        number of words written so far (saturates at MAX_WORDS)
//   done / error      image accepted / image rejected (terminal until reset)
module instr_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MAX_WORDS  = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [31:0]           write_address,
  output logic [31:0]           write_data,
  output logic                  sig_instr_write,
  output logic                  sig_cpu_hold,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    StHdrHi,
    StHdrLo,
    StPayload,
    StCheck,
    StDone,
    StError
  } state_e;

  localparam logic [16:0]         LP_MAX_N  = 17'(MAX_WORDS);
  localparam logic [ADDR_WIDTH:0] LP_MAX_WC = (ADDR_WIDTH + 1)'(MAX_WORDS);

  state_e                  r_state;
  logic [7:0]              r_n_hi;
  logic [15:0]             r_words_left;
  logic [23:0]             r_asm;
  logic [1:0]              r_byte_cnt;
  logic [7:0]              r_xor;
  logic [ADDR_WIDTH-1:0]   r_word_idx;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [31:0]             r_data;
  logic                    r_wr;
  logic [ADDR_WIDTH:0]     r_word_count;
  logic                    r_done;
  logic                    r_error;
  logic                    r_hold;

  logic                    w_in_ready;
  logic                    w_accept;
  logic [15:0]             w_n;
  logic [31:0]             w_word;

  assign w_in_ready = (r_state != StDone) && (r_state != StError);
  assign w_accept   = in_valid && w_in_ready;
  assign w_n        = {r_n_hi, in_data};
  assign w_word     = {r_asm, in_data};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= StHdrHi;
      r_n_hi       <= '0;
      r_words_left <= '0;
      r_asm        <= '0;
      r_byte_cnt   <= '0;
      r_xor        <= '0;
      r_word_idx   <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_wr         <= 1'b0;
      r_word_count <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_hold       <= 1'b1;
    end else begin
      // Strobe is a single-cycle pulse unless re-armed below.
      r_wr <= 1'b0;
      if (w_accept) begin
        unique case (r_state)
          StHdrHi: begin
            r_n_hi  <= in_data;
            r_state <= StHdrLo;
          end
          StHdrLo: begin
            r_words_left <= w_n;
            if ({1'b0, w_n} > LP_MAX_N) begin
              r_state <= StError;
              r_error <= 1'b1;
            end else if (w_n == 16'd0) begin
              r_state <= StCheck;
            end else begin
              r_state <= StPayload;
            end
          end
          StPayload: begin
            r_asm      <= w_word[23:0];
            r_xor      <= r_xor ^ in_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_data       <= w_word;
              r_addr       <= r_word_idx;
              r_wr         <= 1'b1;
              r_word_idx   <= r_word_idx + 1'b1;
              r_words_left <= r_words_left - 16'd1;
              if (r_word_count != LP_MAX_WC) begin
                r_word_count <= r_word_count + 1'b1;
              end
              if (r_words_left == 16'd1) begin
                r_state <= StCheck;
              end
            end
          end
          StCheck: begin
            if (in_data == r_xor) begin
              r_state <= StDone;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
            end else begin
              r_state <= StError;
              r_error <= 1'b1;
            end
          end
          default: begin
            // StDone / StError never accept (in_ready is low).
          end
        endcase
      end
    end
  end

  assign in_ready        = w_in_ready;
  assign write_address   = {{(32 - ADDR_WIDTH){1'b0}}, r_addr};
  assign write_data      = r_data;
  assign sig_instr_write = r_wr;
  assign sig_cpu_hold    = r_hold;
  assign word_count      = r_word_count;
  assign done            = r_done;
  assign error           = r_error;

endmodule
